// File: rtl/banked_regfile_if.sv
// Register-file bus: mode, read ports, write port, PC control and error status.
interface banked_regfile_if #(
    parameter int DATA_W = 32,
    parameter int NRD    = 3
);
    logic [4:0]          mode;
    logic [NRD*4-1:0]    r_addr;
    logic [NRD*DATA_W-1:0] r_data;
    logic [NRD-1:0]      r_err;
    logic                we;
    logic [3:0]          w_addr;
    logic [DATA_W-1:0]   w_data;
    logic                pc_we;
    logic                pc_inc;
    logic [DATA_W-1:0]   pc_data;
    logic [DATA_W-1:0]   pc;
    logic                err_clr;
    logic                w_err;

    modport master (
        output mode, r_addr, we, w_addr, w_data, pc_we, pc_inc, pc_data, err_clr,
        input  r_data, r_err, pc, w_err
    );

    modport slave (
        input  mode, r_addr, we, w_addr, w_data, pc_we, pc_inc, pc_data, err_clr,
        output r_data, r_err, pc, w_err
    );
endinterface

// File: rtl/banked_regfile.sv
// Mode-banked register file: user r0-r14, fiq r8-r14, per-mode r13/r14,
// hyp r13, plus a PC that reads back as address 15.
module banked_regfile #(
    parameter int DATA_W  = 32,
    parameter int NRD     = 3,
    parameter int PC_STEP = 4,
    parameter int BYPASS  = 1
) (
    input logic             clk,
    input logic             rst,
    banked_regfile_if.slave bus
);
    // Physical layout: 0-14 user, 15-21 fiq r8-r14, then r13/r14 pairs for
    // irq(22) svc(24) mon(26) abt(28) und(30), and hyp r13 at 32.
    localparam int unsigned NPHYS = 33;

    logic [DATA_W-1:0] regs [NPHYS];
    logic [DATA_W-1:0] pc_q;
    logic              w_err_q;
    logic              wr_ok;
    logic              wr_bad;
    logic [5:0]        wr_idx;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]    rd_err;

    function automatic logic mode_ok(input logic [4:0] m);
        if (!m[4]) return 1'b0;
        case (m[3:0])
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110,
            4'b0111, 4'b1010, 4'b1011, 4'b1111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] phys_idx(input logic [3:0] m, input logic [3:0] a);
        logic [5:0] idx;
        logic [5:0] off;
        idx = {2'b00, a};
        off = {5'd0, (a == 4'd14)};
        if (m == 4'b0001 && a >= 4'd8) begin
            idx = {2'b00, a} + 6'd7;
        end else if (a == 4'd13 || a == 4'd14) begin
            case (m)
                4'b0010: idx = 6'd22 + off;
                4'b0011: idx = 6'd24 + off;
                4'b0110: idx = 6'd26 + off;
                4'b0111: idx = 6'd28 + off;
                4'b1011: idx = 6'd30 + off;
                4'b1010: if (a == 4'd13) idx = 6'd32;
                default: ;
            endcase
        end
        return idx;
    endfunction

    // Classify the current write request and find its physical target.
    always_comb begin
        wr_ok  = bus.we && mode_ok(bus.mode) && (bus.w_addr != 4'hF);
        wr_bad = bus.we && !wr_ok;
        wr_idx = phys_idx(bus.mode[3:0], bus.w_addr);
    end

    // Register storage update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NPHYS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_idx] <= bus.w_data;
        end
    end

    // Program counter: load beats increment beats hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             pc_q <= '0;
        else if (bus.pc_we)  pc_q <= bus.pc_data;
        else if (bus.pc_inc) pc_q <= pc_q + DATA_W'(PC_STEP);
    end

    // Sticky write error; a new error wins over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              w_err_q <= 1'b0;
        else if (wr_bad)      w_err_q <= 1'b1;
        else if (bus.err_clr) w_err_q <= 1'b0;
    end

    // Combinational read ports with optional write forwarding (disabled in reset).
    always_comb begin
        rd_data = '0;
        rd_err  = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            logic [3:0] a;
            logic [5:0] idx;
            a   = bus.r_addr[4*k +: 4];
            idx = phys_idx(bus.mode[3:0], a);
            if (a == 4'hF) begin
                rd_data[k*DATA_W +: DATA_W] = pc_q;
            end else if (!mode_ok(bus.mode)) begin
                rd_err[k] = 1'b1;
            end else if (BYPASS != 0 && wr_ok && !rst && idx == wr_idx) begin
                rd_data[k*DATA_W +: DATA_W] = bus.w_data;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs[idx];
            end
        end
    end

    assign bus.r_data = rd_data;
    assign bus.r_err  = rd_err;
    assign bus.pc     = pc_q;
    assign bus.w_err  = w_err_q;
endmodule

// File: tb/tb_banked_regfile.sv
// Self-checking bench for banked_regfile: directed table, corner sequences,
// and randomized traffic against a key-per-owner register model.
module tb_banked_regfile;
    localparam int DW   = 32;
    localparam int NRD  = 3;
    localparam int STEP = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    banked_regfile_if #(.DATA_W(DW), .NRD(NRD)) bus ();

    banked_regfile #(.DATA_W(DW), .NRD(NRD), .PC_STEP(STEP), .BYPASS(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [4:0] vmodes [9] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110,
                               5'b10111, 5'b11010, 5'b11011, 5'b11111};

    // Model: each architectural register is named by (owning mode, address).
    logic [DW-1:0] m [256];
    logic [DW-1:0] mpc;
    logic          merr;

    function automatic bit valid_mode(input logic [4:0] md);
        foreach (vmodes[i]) if (vmodes[i] == md) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int key(input logic [4:0] md, input logic [3:0] a);
        int owner;
        owner = 0;
        case (md[3:0])
            4'd1:                     if (a >= 8) owner = 1;
            4'd2, 4'd3, 4'd6, 4'd7, 4'd11: if (a == 13 || a == 14) owner = int'(md[3:0]);
            4'd10:                    if (a == 13) owner = 10;
            default: ;
        endcase
        return owner * 16 + int'(a);
    endfunction

    function automatic logic [DW-1:0] port_data(input int k);
        return bus.r_data[k*DW +: DW];
    endfunction

    task automatic set_idle();
        bus.mode = 5'b10000; bus.we = 0; bus.w_addr = 0; bus.w_data = 0;
        bus.pc_we = 0; bus.pc_inc = 0; bus.pc_data = 0; bus.err_clr = 0;
        bus.r_addr = {NRD{4'hF}};
    endtask

    typedef struct {
        logic [4:0]  md;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t tbl [$];

    initial begin
        logic [3:0] a;
        logic [DW-1:0] ed;
        logic ee;
        bit v;

        tbl.push_back('{5'b10000, 1, 13, 32'hAAAA_0001, 13, 32'hAAAA_0001, 0});
        tbl.push_back('{5'b10011, 1, 13, 32'h5555_0002, 13, 32'h5555_0002, 0});
        tbl.push_back('{5'b10000, 0, 0, 0, 13, 32'hAAAA_0001, 0});
        tbl.push_back('{5'b10011, 0, 0, 0, 13, 32'h5555_0002, 0});
        tbl.push_back('{5'b10010, 0, 0, 0, 13, 32'h0, 0});
        tbl.push_back('{5'b10001, 1, 8, 32'h11, 8, 32'h11, 0});
        tbl.push_back('{5'b10000, 0, 0, 0, 8, 32'h0, 0});
        tbl.push_back('{5'b10001, 0, 0, 0, 8, 32'h11, 0});
        tbl.push_back('{5'b10001, 1, 7, 32'h77, 0, 32'h0, 0});
        tbl.push_back('{5'b10000, 0, 0, 0, 7, 32'h77, 0});
        tbl.push_back('{5'b10100, 0, 0, 0, 5, 32'h0, 1});
        tbl.push_back('{5'b11010, 1, 14, 32'h1414, 14, 32'h1414, 0});
        tbl.push_back('{5'b10000, 0, 0, 0, 14, 32'h1414, 0});
        tbl.push_back('{5'b11010, 1, 13, 32'h1313, 13, 32'h1313, 0});
        tbl.push_back('{5'b10000, 0, 0, 0, 13, 32'hAAAA_0001, 0});
        tbl.push_back('{5'b11010, 0, 0, 0, 13, 32'h1313, 0});
        tbl.push_back('{5'b10001, 0, 0, 0, 14, 32'h0, 0});
        tbl.push_back('{5'b11111, 0, 0, 0, 13, 32'hAAAA_0001, 0});
        tbl.push_back('{5'b11011, 1, 14, 32'hABCD, 14, 32'hABCD, 0});
        tbl.push_back('{5'b10111, 0, 0, 0, 14, 32'h0, 0});
        tbl.push_back('{5'b11011, 0, 0, 0, 15, 32'h0, 0});

        // Reset state
        set_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.r_addr = {NRD{4'd0}};
        #1;
        chk("reset pc", bus.pc, 0);
        chk("reset w_err", bus.w_err, 0);
        chk("reset r0", port_data(0), 0);
        chk("reset r_err", bus.r_err, 0);
        rst = 0;

        // Directed banking table
        foreach (tbl[i]) begin
            @(negedge clk);
            set_idle();
            bus.mode = tbl[i].md; bus.we = tbl[i].we;
            bus.w_addr = tbl[i].wa; bus.w_data = tbl[i].wd;
            bus.r_addr = {NRD{tbl[i].ra}};
            #1;
            for (int k = 0; k < NRD; k++) begin
                chk($sformatf("tbl%0d p%0d data", i, k), port_data(k), tbl[i].exp_d);
                chk($sformatf("tbl%0d p%0d err", i, k), bus.r_err[k], tbl[i].exp_e);
            end
            @(posedge clk);
        end

        // Forwarding on port 2, invalid-mode reads
        @(negedge clk);
        set_idle();
        bus.we = 1; bus.w_addr = 3; bus.w_data = 32'hDEAD;
        bus.r_addr = {4'd3, 4'd0, 4'd1};
        #1;
        chk("bypass p2", port_data(2), 32'hDEAD);
        chk("bypass p0 r1", port_data(0), 0);
        @(posedge clk);
        @(negedge clk);
        set_idle();
        bus.mode = 5'b10100;
        bus.r_addr = {4'd5, 4'hF, 4'd5};
        #1;
        chk("invalid r5 data", port_data(0), 0);
        chk("invalid r_err", bus.r_err, 3'b101);
        chk("invalid r15 pc", port_data(1), 0);

        // PC priority and wrap
        @(negedge clk);
        set_idle();
        bus.pc_data = 32'h100; bus.pc_we = 1; bus.pc_inc = 1;
        @(posedge clk); #1;
        chk("pc load wins", bus.pc, 32'h100);
        @(negedge clk);
        bus.pc_we = 0;
        @(posedge clk); #1;
        chk("pc inc", bus.pc, 32'h104);
        @(negedge clk);
        bus.pc_we = 1; bus.pc_inc = 0; bus.pc_data = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        chk("pc load top", bus.pc, 32'hFFFF_FFFC);
        @(negedge clk);
        bus.pc_we = 0; bus.pc_inc = 1;
        @(posedge clk); #1;
        chk("pc wrap", bus.pc, 0);

        // Write error: addr 15, set-wins, clear
        @(negedge clk);
        set_idle();
        bus.we = 1; bus.w_addr = 15; bus.w_data = 32'h1234;
        bus.r_addr = {NRD{4'd3}};
        @(posedge clk); #1;
        chk("err addr15 set", bus.w_err, 1);
        chk("err addr15 pc", bus.pc, 0);
        chk("err addr15 r3", port_data(0), 32'hDEAD);
        @(negedge clk);
        bus.mode = 5'b00000; bus.w_addr = 2; bus.err_clr = 1;
        @(posedge clk); #1;
        chk("err set wins", bus.w_err, 1);
        @(negedge clk);
        set_idle();
        bus.err_clr = 1;
        bus.r_addr = {NRD{4'd2}};
        #1;
        chk("err no write r2", port_data(0), 0);
        @(posedge clk); #1;
        chk("err clear", bus.w_err, 0);

        // Asynchronous reset mid-cycle, writes ignored while held
        @(negedge clk);
        set_idle();
        bus.we = 1; bus.w_addr = 4; bus.w_data = 32'h44;
        bus.pc_we = 1; bus.pc_data = 32'h200;
        @(posedge clk);
        @(negedge clk);
        set_idle();
        bus.we = 1; bus.w_addr = 15;
        @(posedge clk);
        @(negedge clk);
        set_idle();
        bus.r_addr = {NRD{4'd4}};
        #1;
        chk("pre-rst r4", port_data(0), 32'h44);
        chk("pre-rst pc", bus.pc, 32'h200);
        chk("pre-rst w_err", bus.w_err, 1);
        #2 rst = 1;
        #1;
        chk("rst r4", port_data(0), 0);
        chk("rst pc", bus.pc, 0);
        chk("rst w_err", bus.w_err, 0);
        bus.we = 1; bus.w_addr = 4; bus.w_data = 32'h99; bus.pc_inc = 1;
        #1;
        chk("rst no bypass", port_data(1), 0);
        @(posedge clk); #1;
        chk("rst held r4", port_data(0), 0);
        chk("rst held pc", bus.pc, 0);
        @(negedge clk);
        set_idle();
        rst = 0;

        // Randomized traffic against the model (DUT state is all-zero here)
        foreach (m[i]) m[i] = '0;
        mpc = '0;
        merr = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ($urandom_range(3) != 0) bus.mode = vmodes[$urandom_range(8)];
            else bus.mode = 5'($urandom);
            bus.we = ($urandom_range(9) < 6);
            bus.w_addr = 4'($urandom);
            bus.w_data = $urandom;
            bus.pc_we = ($urandom_range(7) == 0);
            bus.pc_inc = $urandom_range(1) == 1;
            bus.pc_data = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : $urandom;
            bus.err_clr = ($urandom_range(7) == 0);
            for (int k = 0; k < NRD; k++) begin
                a = ($urandom_range(2) == 0) ? bus.w_addr : 4'($urandom);
                bus.r_addr[4*k +: 4] = a;
            end
            #1;
            v = valid_mode(bus.mode);
            for (int k = 0; k < NRD; k++) begin
                a = bus.r_addr[4*k +: 4];
                ee = 0;
                if (a == 15) ed = mpc;
                else if (!v) begin ed = 0; ee = 1; end
                else if (bus.we && bus.w_addr != 15 && key(bus.mode, bus.w_addr) == key(bus.mode, a))
                    ed = bus.w_data;
                else ed = m[key(bus.mode, a)];
                chk($sformatf("rnd%0d p%0d data", c, k), port_data(k), ed);
                chk($sformatf("rnd%0d p%0d err", c, k), bus.r_err[k], ee);
            end
            @(posedge clk);
            if (bus.we && v && bus.w_addr != 15) m[key(bus.mode, bus.w_addr)] = bus.w_data;
            if (bus.we && !(v && bus.w_addr != 15)) merr = 1;
            else if (bus.err_clr) merr = 0;
            if (bus.pc_we) mpc = bus.pc_data;
            else if (bus.pc_inc) mpc = mpc + STEP;
            #1;
            chk($sformatf("rnd%0d pc", c), bus.pc, mpc);
            chk($sformatf("rnd%0d w_err", c), bus.w_err, merr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/banked_regfile.md
BANKED_REGFILE -- requirements
Module: banked_regfile

Interface
REQ-001 Parameter DATA_W, 32, register and PC data width in bits (>=8).
REQ-002 Parameter NRD, 3, number of independent read ports (1..8).
REQ-003 Parameter PC_STEP, 4, increment added to PC on pc_inc.
REQ-004 Parameter BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 mode  in  5  processor mode field M[4:0].
REQ-008 r_addr  in  NRD*4  packed read addresses; port k uses bits [4k+3:4k].
REQ-009 r_data  out  NRD*DATA_W  packed read data; port k uses bits [k*DATA_W+DATA_W-1:k*DATA_W].
REQ-010 r_err  out  NRD  per-port combinational read-error flag.
REQ-011 we  in  1  register write enable.
REQ-012 w_addr  in  4  write address.
REQ-013 w_data  in  DATA_W  write data.
REQ-014 pc_we  in  1  PC load enable.
REQ-015 pc_inc  in  1  PC increment enable.
REQ-016 pc_data  in  DATA_W  PC load value.
REQ-017 pc  out  DATA_W  current PC, registered.
REQ-018 err_clr  in  1  clears sticky write error.
REQ-019 w_err  out  1  sticky registered write-error flag.

Function
REQ-020 Valid modes SHALL be mode[4]=1 with mode[3:0] in {0000 usr, 0001 fiq, 0010 irq, 0011 svc, 0110 mon, 0111 abt, 1010 hyp, 1011 und, 1111 sys}; all others invalid.
REQ-021 Storage SHALL be: user r0-r14; fiq r8-r14; r13+r14 for irq, svc, mon, abt, und; r13 only for hyp; PC.
REQ-022 Mapping SHALL be: usr/sys/hyp(r14) use user bank; fiq uses fiq bank for r8-r14; irq/svc/mon/abt/und use own r13/r14; hyp uses own r13; all other addresses 0-14 map to user bank.
REQ-023 Reads SHALL be combinational; address 15 returns pc for any mode, including invalid.
REQ-024 Read of addresses 0-14 in an invalid mode SHALL return 0 and assert r_err[k]; otherwise r_err[k]=0.
REQ-025 When BYPASS=1 and we=1, a valid write, and a port reads the same physical register, that port SHALL return w_data in the same cycle.
REQ-026 Write with we=1, valid mode, w_addr<=14 SHALL update the mapped physical register at the rising edge; no other register changes.
REQ-027 Write with we=1 and (invalid mode or w_addr=15) SHALL change no register and set w_err at that edge.
REQ-028 w_err SHALL stay 1 until err_clr; err_clr with a simultaneous new error SHALL leave w_err=1 (set wins).
REQ-029 PC update priority per edge: pc_we loads pc_data; else pc_inc adds PC_STEP modulo 2^DATA_W; else hold.
REQ-030 PC logic SHALL be independent of mode and of we/w_addr; w_addr=15 never modifies PC.
REQ-031 Mode change SHALL take effect on reads combinationally and on writes at the next edge with no pipeline penalty.

Reset
REQ-032 rst=1 SHALL asynchronously clear every banked and user register, pc and w_err to 0.
REQ-033 Writes, PC updates and err_clr SHALL be ignored while rst=1; first update occurs on the first rising edge after rst deasserts.
REQ-034 Read ports SHALL return 0 for addresses 0-15 during reset when mode is valid.

Verification
REQ-035 mode=10000, write r13=0xAAAA_0001; mode=10011, write r13=0x5555_0002; read r13 in usr -> 0xAAAA0001, in svc -> 0x55550002, in irq -> 0.
REQ-036 mode=10001, write r8=0x11; mode=10000 read r8 -> 0, mode=10001 read r8 -> 0x11; r7 write in fiq visible in usr.
REQ-037 pc_data=0x100, pc_we=1 and pc_inc=1 same edge -> pc=0x100; next edge pc_inc only -> 0x104; pc=0xFFFF_FFFC + inc -> 0.
REQ-038 we=1, w_addr=15 -> no register/PC change, w_err=1; err_clr with simultaneous mode=00000 write -> w_err stays 1; err_clr alone -> 0.
REQ-039 BYPASS=1, write r3=0xDEAD while port 2 reads r3 -> r_data port 2 = 0xDEAD same cycle; mode=10100 read r5 -> 0 with r_err=1.
REQ-040 Assert rst mid-sequence between edges -> all outputs 0 immediately; with rst held, writes ignored.
